fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request, tracks the PC and
// feeds the IF/ID register, with a one-entry skid buffer for words returned during a stall.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_data_i,
  output logic [31:0] pc_o,
  output logic        id_valid_o,
  output logic [31:0] id_instruction_o,
  output logic [31:0] id_pc_plus_4_o
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] req_addr_q;
  logic [31:0] skid_q;
  logic        skid_valid_q;
  logic        id_valid_q;
  logic [31:0] id_instr_q;
  logic [31:0] id_pc4_q;

  logic [31:0] target_pc;
  logic [31:0] seq_pc;
  logic        advance;

  assign target_pc = redirect_pc_i & ~32'h0000_0003;
  assign seq_pc    = req_addr_q + 32'd4;
  // A flush lets the pipeline move as if unstalled; only the IF/ID valid bit is squashed.
  assign advance   = flush_i || !stall_i;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      skid_q       <= 32'h0;
      skid_valid_q <= 1'b0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= 32'h0;
      id_pc4_q     <= 32'h0;
    end else if (redirect_i) begin
      pc_q         <= target_pc;
      id_valid_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      req_q        <= 1'b1;
      // An outstanding request must still complete before the target can be fetched.
      if ((state_q == FETCH || state_q == DISCARD) && !imem_ready_i) begin
        state_q <= DISCARD;
      end else begin
        state_q    <= FETCH;
        req_addr_q <= target_pc;
      end
    end else begin
      if (flush_i) id_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q    <= FETCH;
          req_q      <= 1'b1;
          req_addr_q <= pc_q;
        end
        FETCH: begin
          if (imem_ready_i) begin
            if (advance) begin
              pc_q       <= seq_pc;
              req_addr_q <= seq_pc;
              if (!flush_i) begin
                id_valid_q <= 1'b1;
                id_instr_q <= imem_data_i;
                id_pc4_q   <= seq_pc;
              end
            end else begin
              skid_q       <= imem_data_i;
              skid_valid_q <= 1'b1;
              state_q      <= HOLD;
              req_q        <= 1'b0;
            end
          end else if (!stall_i) begin
            id_valid_q <= 1'b0;
          end
        end
        HOLD: begin
          if (advance) begin
            pc_q         <= seq_pc;
            req_addr_q   <= seq_pc;
            state_q      <= FETCH;
            req_q        <= 1'b1;
            skid_valid_q <= 1'b0;
            if (!flush_i) begin
              id_valid_q <= skid_valid_q;
              id_instr_q <= skid_q;
              id_pc4_q   <= seq_pc;
            end
          end
        end
        DISCARD: begin
          if (imem_ready_i) begin
            state_q    <= FETCH;
            req_addr_q <= pc_q;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o       = req_q;
  assign imem_addr_o      = req_addr_q;
  assign pc_o             = pc_q;
  assign id_valid_o       = id_valid_q;
  assign id_instruction_o = id_instr_q;
  assign id_pc_plus_4_o   = id_pc4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed vector table, reset corner sequences, and a random
// run checked against an in-order instruction-stream model.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i, flush_i, redirect_i, imem_ready_i;
  logic [31:0] redirect_pc_i, imem_data_i;
  logic        imem_req_o, id_valid_o;
  logic [31:0] imem_addr_o, pc_o, id_instruction_o, id_pc_plus_4_o;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.RESET_PC(RPC)) dut (
    .clk(clk), .reset(rst_n), .stall_i(stall_i), .flush_i(flush_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ready_i(imem_ready_i), .imem_data_i(imem_data_i), .pc_o(pc_o),
    .id_valid_o(id_valid_o), .id_instruction_o(id_instruction_o),
    .id_pc_plus_4_o(id_pc_plus_4_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, redirect;
    logic [31:0] rpc;
    logic        ready;
    logic [31:0] data;
    logic        req;
    logic [31:0] addr, pc;
    logic        idv;
    logic [31:0] instr, pc4;
  } vec_t;

  vec_t vecs [0:21];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic setv(input int i, input logic st, input logic fl, input logic rd,
                      input logic [31:0] rpc, input logic rdy, input logic [31:0] dat,
                      input logic req, input logic [31:0] addr, input logic [31:0] pc,
                      input logic idv, input logic [31:0] ins, input logic [31:0] p4);
    vecs[i] = '{st, fl, rd, rpc, rdy, dat, req, addr, pc, idv, ins, p4};
  endtask

  task automatic drive(input logic st, input logic fl, input logic rd, input logic [31:0] rpc,
                       input logic rdy, input logic [31:0] dat);
    stall_i = st; flush_i = fl; redirect_i = rd; redirect_pc_i = rpc;
    imem_ready_i = rdy; imem_data_i = dat;
  endtask

  initial begin
    logic [129:0] act_row, exp_row;
    logic [31:0]  exp_next, tgt, p_addr, p_instr, p_pc4;
    logic         p_req, p_idv;
    int           deliveries;

    //   i  st fl rd rpc           rdy dat           req addr          pc            idv instr         pc4
    setv( 0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040_0000, 32'h0040_0000, 0, 32'h0,        32'h0);
    setv( 1, 0, 0, 0, 32'h0,        1, 32'h2008_0005, 1, 32'h0040_0004, 32'h0040_0004, 1, 32'h2008_0005, 32'h0040_0004);
    setv( 2, 0, 0, 0, 32'h0,        1, 32'h2009_0003, 1, 32'h0040_0008, 32'h0040_0008, 1, 32'h2009_0003, 32'h0040_0008);
    setv( 3, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040_0008, 32'h0040_0008, 0, 32'h2009_0003, 32'h0040_0008);
    setv( 4, 0, 0, 0, 32'h0,        1, 32'h1111_1111, 1, 32'h0040_000C, 32'h0040_000C, 1, 32'h1111_1111, 32'h0040_000C);
    setv( 5, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040_000C, 32'h0040_000C, 0, 32'h1111_1111, 32'h0040_000C);
    setv( 6, 0, 0, 0, 32'h0,        1, 32'h2222_2222, 1, 32'h0040_0010, 32'h0040_0010, 1, 32'h2222_2222, 32'h0040_0010);
    setv( 7, 1, 0, 0, 32'h0,        1, 32'h3333_3333, 0, 32'h0040_0010, 32'h0040_0010, 1, 32'h2222_2222, 32'h0040_0010);
    setv( 8, 1, 0, 0, 32'h0,        1, 32'hDEAD_BEEF, 0, 32'h0040_0010, 32'h0040_0010, 1, 32'h2222_2222, 32'h0040_0010);
    setv( 9, 1, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0040_0010, 32'h0040_0010, 1, 32'h2222_2222, 32'h0040_0010);
    setv(10, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040_0014, 32'h0040_0014, 1, 32'h3333_3333, 32'h0040_0014);
    setv(11, 0, 0, 0, 32'h0,        1, 32'h4444_4444, 1, 32'h0040_0018, 32'h0040_0018, 1, 32'h4444_4444, 32'h0040_0018);
    setv(12, 0, 0, 1, 32'h0040_0043, 0, 32'h0,       1, 32'h0040_0018, 32'h0040_0040, 0, 32'h4444_4444, 32'h0040_0018);
    setv(13, 0, 0, 0, 32'h0,        0, 32'h0,        1, 32'h0040_0018, 32'h0040_0040, 0, 32'h4444_4444, 32'h0040_0018);
    setv(14, 0, 0, 0, 32'h0,        1, 32'h5555_5555, 1, 32'h0040_0040, 32'h0040_0040, 0, 32'h4444_4444, 32'h0040_0018);
    setv(15, 0, 0, 0, 32'h0,        1, 32'h6666_6666, 1, 32'h0040_0044, 32'h0040_0044, 1, 32'h6666_6666, 32'h0040_0044);
    setv(16, 1, 1, 1, 32'h0040_0100, 1, 32'h7777_7777, 1, 32'h0040_0100, 32'h0040_0100, 0, 32'h6666_6666, 32'h0040_0044);
    setv(17, 0, 1, 0, 32'h0,        1, 32'h8888_8888, 1, 32'h0040_0104, 32'h0040_0104, 0, 32'h6666_6666, 32'h0040_0044);
    setv(18, 0, 0, 0, 32'h0,        1, 32'h9999_9999, 1, 32'h0040_0108, 32'h0040_0108, 1, 32'h9999_9999, 32'h0040_0108);
    setv(19, 0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0,       1, 32'h0040_0108, 32'hFFFF_FFFC, 0, 32'h9999_9999, 32'h0040_0108);
    setv(20, 0, 0, 0, 32'h0,        1, 32'h1234_0000, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, 32'h9999_9999, 32'h0040_0108);
    setv(21, 0, 0, 0, 32'h0,        1, 32'hAAAA_AAAA, 1, 32'h0000_0000, 32'h0000_0000, 1, 32'hAAAA_AAAA, 32'h0000_0000);

    rst_n = 1'b0;
    drive(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    chk("reset req",   {31'h0, imem_req_o}, 32'h0);
    chk("reset addr",  imem_addr_o, RPC);
    chk("reset pc",    pc_o, RPC);
    chk("reset valid", {31'h0, id_valid_o}, 32'h0);
    chk("reset instr", id_instruction_o, 32'h0);
    chk("reset pc4",   id_pc_plus_4_o, 32'h0);

    rst_n = 1'b1;
    #1 chk("idle no req", {31'h0, imem_req_o}, 32'h0);
    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].redirect, vecs[i].rpc, vecs[i].ready, vecs[i].data);
      @(posedge clk); #1;
      act_row = {imem_req_o, imem_addr_o, pc_o, id_valid_o, id_instruction_o, id_pc_plus_4_o};
      exp_row = {vecs[i].req, vecs[i].addr, vecs[i].pc, vecs[i].idv, vecs[i].instr, vecs[i].pc4};
      checks++;
      if (act_row !== exp_row) begin
        errors++;
        $display("FAIL vec%0d: got req/addr/pc/v/ins/pc4=%h expected %h", i, act_row, exp_row);
      end else begin
        $display("vec%0d ok: addr=%08h pc=%08h v=%0d ins=%08h pc4=%08h", i, imem_addr_o, pc_o,
                 id_valid_o, id_instruction_o, id_pc_plus_4_o);
      end
      @(negedge clk);
    end

    // Asynchronous reset while a stalled word sits in the skid buffer.
    drive(1, 0, 0, 32'h0, 1, 32'hBBBB_BBBB);
    @(posedge clk); #1;
    chk("hold req", {31'h0, imem_req_o}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst req",   {31'h0, imem_req_o}, 32'h0);
    chk("async rst valid", {31'h0, id_valid_o}, 32'h0);
    chk("async rst pc",    pc_o, RPC);
    chk("async rst addr",  imem_addr_o, RPC);
    chk("async rst instr", id_instruction_o, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst req",   {31'h0, imem_req_o}, 32'h1);
    chk("post rst addr",  imem_addr_o, RPC);
    chk("post rst valid", {31'h0, id_valid_o}, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 32'h0, 1, 32'h1234_5678);
    @(posedge clk); #1;
    chk("post rst instr", id_instruction_o, 32'h1234_5678);
    chk("post rst pc4",   id_pc_plus_4_o, RPC + 32'd4);
    chk("post rst valid1", {31'h0, id_valid_o}, 32'h1);

    // Random run: deliveries must form the in-order stream from the last redirect target.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_next = RPC;
    deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      stall_i       = ($urandom % 4) == 0;
      redirect_i    = ($urandom % 40) == 0;
      redirect_pc_i = $urandom;
      flush_i       = 1'b0;
      imem_ready_i  = ($urandom % 3) != 0;
      imem_data_i   = imem_ready_i ? memf(imem_addr_o) : $urandom;
      p_req = imem_req_o; p_addr = imem_addr_o; p_idv = id_valid_o;
      p_instr = id_instruction_o; p_pc4 = id_pc_plus_4_o;
      @(posedge clk); #1;
      if (p_req && !imem_ready_i) begin
        chk("addr stable", imem_addr_o, p_addr);
        chk("req held", {31'h0, imem_req_o}, 32'h1);
      end
      chk("addr aligned", {30'h0, imem_addr_o[1:0]}, 32'h0);
      if (redirect_i) begin
        tgt = redirect_pc_i & ~32'h3;
        chk("redirect pc", pc_o, tgt);
        chk("redirect valid", {31'h0, id_valid_o}, 32'h0);
        exp_next = tgt;
      end else if (stall_i) begin
        chk("stall frozen", {id_valid_o == p_idv, id_instruction_o == p_instr,
                             id_pc_plus_4_o == p_pc4}, 3'b111);
      end else if (id_valid_o) begin
        chk("stream pc4", id_pc_plus_4_o, exp_next + 32'd4);
        chk("stream instr", id_instruction_o, memf(exp_next));
        $display("rand cyc%0d: delivered pc=%08h ins=%08h", c, exp_next, id_instruction_o);
        exp_next = exp_next + 32'd4;
        deliveries++;
      end
    end
    checks++;
    if (deliveries < 200) begin
      errors++;
      $display("FAIL progress: got %0d deliveries expected at least 200", deliveries);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
